// File: rtl/spi_slave_rx_tx.sv
// SPI mode-0 slave endpoint. The bus (sclk, cs, mosi) is oversampled in the
// system clk domain; received words and transmit words use valid/ready
// handshakes. miso is a registered copy of the tx shift register MSB.
module spi_slave_rx_tx #(
  parameter int SIZE        = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sclk,
  input  logic            cs,
  input  logic            mosi,
  output logic            miso,
  output logic            miso_oe,
  input  logic [SIZE-1:0] tx_data,
  input  logic            tx_valid,
  output logic            tx_ready,
  output logic [SIZE-1:0] rx_data,
  output logic            rx_valid,
  input  logic            rx_ready,
  output logic            overrun,
  output logic            underrun,
  input  logic            flag_clr
);

  localparam int CW = $clog2(SIZE + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_d;
  logic                   cs_d;
  logic                   sclk_last;
  logic                   cs_last;
  logic                   sclk_rise_p1;
  logic                   sclk_fall_p1;
  logic                   cs_fall_p1;
  logic                   cs_rise_p1;
  logic                   mosi_p1;
  logic [CW-1:0]          cnt;
  logic [SIZE-1:0]        tx_hold;
  logic [SIZE-1:0]        tx_shift;
  logic [SIZE-1:0]        rx_shift;
  logic [SIZE-1:0]        word_p2;
  logic                   done_p2;
  logic                   under_pend;
  logic                   load_now;
  logic                   under_set;
  logic                   ovr_set;
  logic                   tx_hand;

  assign sclk_last = sclk_sync[SYNC_STAGES-1];
  assign cs_last   = cs_sync[SYNC_STAGES-1];

  // Synchronizer chains plus one delay flop each for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_last;
      cs_d      <= cs_last;
    end
  end

  // Registered 1-clk edge pulses; mosi is registered alongside so it lines
  // up with the sclk sample that produced the rise pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_rise_p1 <= 1'b0;
      sclk_fall_p1 <= 1'b0;
      cs_fall_p1   <= 1'b0;
      cs_rise_p1   <= 1'b0;
      mosi_p1      <= 1'b0;
    end else begin
      sclk_rise_p1 <= sclk_last & ~sclk_d;
      sclk_fall_p1 <= ~sclk_last & sclk_d;
      cs_fall_p1   <= ~cs_last & cs_d;
      cs_rise_p1   <= cs_last & ~cs_d;
      mosi_p1      <= mosi_sync[SYNC_STAGES-1];
    end
  end

  // Load points, underrun commit and tx handshake.
  // An empty-holding-register load only raises underrun once the first bit
  // of that word is actually clocked; the boundary fall that ends the last
  // word of a frame would otherwise flag a word that never starts.
  always_comb begin
    load_now  = 1'b0;
    under_set = 1'b0;
    tx_hand   = tx_valid & tx_ready;
    if (state == LOAD) begin
      load_now = 1'b1;
    end else if (state == SHIFT && !cs_rise_p1) begin
      load_now  = sclk_fall_p1 && (cnt == '0);
      under_set = sclk_rise_p1 && (cnt == '0) && under_pend;
    end
  end

  // Main FSM: tx holding/shift registers, rx shifting, bit count, miso drive
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      tx_hold    <= '0;
      tx_shift   <= '0;
      rx_shift   <= '0;
      word_p2    <= '0;
      done_p2    <= 1'b0;
      tx_ready   <= 1'b1;
      miso       <= 1'b0;
      miso_oe    <= 1'b0;
      under_pend <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      done_p2 <= 1'b0;
      case (state)
        IDLE: begin
          miso    <= 1'b0;
          miso_oe <= 1'b0;
          if (cs_fall_p1) begin
            state   <= LOAD;
            miso_oe <= 1'b1;
          end
        end
        LOAD: begin
          cnt   <= '0;
          miso  <= 1'b0;
          state <= cs_rise_p1 ? IDLE : SHIFT;
          if (cs_rise_p1) begin
            miso_oe <= 1'b0;
          end
        end
        SHIFT: begin
          if (cs_rise_p1) begin
            state      <= IDLE;
            cnt        <= '0;
            miso       <= 1'b0;
            miso_oe    <= 1'b0;
            under_pend <= 1'b0;
          end else begin
            miso <= tx_shift[SIZE-1];
            if (sclk_rise_p1) begin
              rx_shift <= {rx_shift[SIZE-2:0], mosi_p1};
              if (cnt == CW'(SIZE - 1)) begin
                cnt     <= '0;
                done_p2 <= 1'b1;
                word_p2 <= {rx_shift[SIZE-2:0], mosi_p1};
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
            if (sclk_fall_p1 && cnt != '0) begin
              tx_shift <= {tx_shift[SIZE-2:0], 1'b0};
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (load_now) begin
        tx_shift   <= tx_ready ? '0 : tx_hold;
        under_pend <= tx_ready;
        tx_ready   <= 1'b1;
      end
      if (under_set) begin
        under_pend <= 1'b0;
      end
      underrun <= under_set | (underrun & ~flag_clr);

      if (tx_hand) begin
        tx_hold  <= tx_data;
        tx_ready <= 1'b0;
      end
    end
  end

  assign ovr_set = done_p2 & rx_valid & ~rx_ready;

  // Received-word handoff with overrun detection
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (done_p2) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= word_p2;
          rx_valid <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      overrun <= ovr_set | (overrun & ~flag_clr);
    end
  end

endmodule
